ysyx_25040109_mem_arb: RTL and testbench

YSYX_25040109_MEM_ARB -- requirements
Module: ysyx_25040109_mem_arb

---
 rtl/ysyx_25040109_mem_arb.sv | 186 ++++++++++++++++++
 tb/tb_ysyx_25040109_mem_arb.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040109_mem_arb.sv
// ysyx_25040109_mem_arb
// Two-master arbiter (IFU fetch, LSU load/store) in front of a single shared
// memory port. One transaction is outstanding at a time.
//
// Ports
//   clock, reset             : single clock, synchronous active-high reset
//   ifu_req_*                : IFU fetch request (valid/ready handshake, addr)
//   ifu_resp_*               : IFU one-cycle response pulse + fetched word
//   lsu_req_*                : LSU request (addr, wen, wdata, wmask)
//   lsu_resp_*               : LSU one-cycle response pulse + load data (0 on store)
//   mem_req_*                : latched request to memory (valid/ready handshake)
//   mem_resp_*               : memory response pulse + read data
//
// Flow: IDLE grants one requester (round-robin on ties), REQ presents the
// latched request until memory accepts, WAIT waits for the response and
// routes it to the owner as a registered one-cycle pulse.
module ysyx_25040109_mem_arb (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_req_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_resp_data,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_req_addr,
  input  logic        lsu_req_wen,
  input  logic [31:0] lsu_req_wdata,
  input  logic [3:0]  lsu_req_wmask,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_resp_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;            // 0 = IFU, 1 = LSU
  logic        last_grant_q, last_grant_d;  // 0 = IFU, 1 = LSU
  logic        txn_wen_q, txn_wen_d;        // store flag kept through WAIT

  logic        mem_req_valid_q, mem_req_valid_d;
  logic [31:0] mem_req_addr_q, mem_req_addr_d;
  logic        mem_req_wen_q, mem_req_wen_d;
  logic [31:0] mem_req_wdata_q, mem_req_wdata_d;
  logic [3:0]  mem_req_wmask_q, mem_req_wmask_d;

  logic        ifu_resp_valid_q, ifu_resp_valid_d;
  logic [31:0] ifu_resp_data_q, ifu_resp_data_d;
  logic        lsu_resp_valid_q, lsu_resp_valid_d;
  logic [31:0] lsu_resp_rdata_q, lsu_resp_rdata_d;

  logic        ifu_grant;
  logic        lsu_grant;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    ifu_grant = 1'b0;
    lsu_grant = 1'b0;
    if (state_q == IDLE) begin
      ifu_grant = ifu_req_valid && (!lsu_req_valid || last_grant_q);
      lsu_grant = lsu_req_valid && (!ifu_req_valid || !last_grant_q);
    end
  end

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    last_grant_d     = last_grant_q;
    txn_wen_d        = txn_wen_q;
    mem_req_valid_d  = mem_req_valid_q;
    mem_req_addr_d   = mem_req_addr_q;
    mem_req_wen_d    = mem_req_wen_q;
    mem_req_wdata_d  = mem_req_wdata_q;
    mem_req_wmask_d  = mem_req_wmask_q;
    ifu_resp_valid_d = 1'b0;
    ifu_resp_data_d  = ifu_resp_data_q;
    lsu_resp_valid_d = 1'b0;
    lsu_resp_rdata_d = lsu_resp_rdata_q;

    case (state_q)
      IDLE: begin
        if (ifu_grant) begin
          state_d         = REQ;
          owner_d         = 1'b0;
          last_grant_d    = 1'b0;
          txn_wen_d       = 1'b0;
          mem_req_valid_d = 1'b1;
          mem_req_addr_d  = ifu_req_addr;
          mem_req_wen_d   = 1'b0;
          mem_req_wdata_d = '0;
          mem_req_wmask_d = '0;
        end else if (lsu_grant) begin
          state_d         = REQ;
          owner_d         = 1'b1;
          last_grant_d    = 1'b1;
          txn_wen_d       = lsu_req_wen;
          mem_req_valid_d = 1'b1;
          mem_req_addr_d  = lsu_req_addr;
          mem_req_wen_d   = lsu_req_wen;
          mem_req_wdata_d = lsu_req_wdata;
          mem_req_wmask_d = lsu_req_wmask;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          // addr/wdata stay latched; only the qualifying fields drop.
          state_d         = WAIT;
          mem_req_valid_d = 1'b0;
          mem_req_wen_d   = 1'b0;
          mem_req_wmask_d = '0;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          state_d = IDLE;
          if (owner_q) begin
            lsu_resp_valid_d = 1'b1;
            lsu_resp_rdata_d = txn_wen_q ? '0 : mem_resp_data;
          end else begin
            ifu_resp_valid_d = 1'b1;
            ifu_resp_data_d  = mem_resp_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      owner_q          <= 1'b0;
      last_grant_q     <= 1'b1;
      txn_wen_q        <= 1'b0;
      mem_req_valid_q  <= 1'b0;
      mem_req_addr_q   <= '0;
      mem_req_wen_q    <= 1'b0;
      mem_req_wdata_q  <= '0;
      mem_req_wmask_q  <= '0;
      ifu_resp_valid_q <= 1'b0;
      ifu_resp_data_q  <= '0;
      lsu_resp_valid_q <= 1'b0;
      lsu_resp_rdata_q <= '0;
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      last_grant_q     <= last_grant_d;
      txn_wen_q        <= txn_wen_d;
      mem_req_valid_q  <= mem_req_valid_d;
      mem_req_addr_q   <= mem_req_addr_d;
      mem_req_wen_q    <= mem_req_wen_d;
      mem_req_wdata_q  <= mem_req_wdata_d;
      mem_req_wmask_q  <= mem_req_wmask_d;
      ifu_resp_valid_q <= ifu_resp_valid_d;
      ifu_resp_data_q  <= ifu_resp_data_d;
      lsu_resp_valid_q <= lsu_resp_valid_d;
      lsu_resp_rdata_q <= lsu_resp_rdata_d;
    end
  end

  assign ifu_req_ready  = ifu_grant;
  assign lsu_req_ready  = lsu_grant;
  assign mem_req_valid  = mem_req_valid_q;
  assign mem_req_addr   = mem_req_addr_q;
  assign mem_req_wen    = mem_req_wen_q;
  assign mem_req_wdata  = mem_req_wdata_q;
  assign mem_req_wmask  = mem_req_wmask_q;
  assign ifu_resp_valid = ifu_resp_valid_q;
  assign ifu_resp_data  = ifu_resp_data_q;
  assign lsu_resp_valid = lsu_resp_valid_q;
  assign lsu_resp_rdata = lsu_resp_rdata_q;

endmodule

// File: tb/tb_ysyx_25040109_mem_arb.sv
module tb_ysyx_25040109_mem_arb;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_resp_data;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_wmask;
  logic        lsu_resp_valid;
  logic [31:0] lsu_resp_rdata;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  ysyx_25040109_mem_arb dut (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rdata(lsu_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] hold_ifu, hold_lsu;

  typedef struct {
    logic        ifu_v;
    logic        lsu_v;
    logic        wen;
    logic [31:0] iaddr;
    logic [31:0] laddr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] mdata;
    logic        exp_lsu;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ifu_req_valid  = 1'b0;
    ifu_req_addr   = '0;
    lsu_req_valid  = 1'b0;
    lsu_req_addr   = '0;
    lsu_req_wen    = 1'b0;
    lsu_req_wdata  = '0;
    lsu_req_wmask  = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    hold_ifu = '0;
    hold_lsu = '0;
  endtask

  task automatic check_all_zero(input string nm);
    chk1({nm, " ifu_req_ready"}, ifu_req_ready, 1'b0);
    chk1({nm, " lsu_req_ready"}, lsu_req_ready, 1'b0);
    chk1({nm, " ifu_resp_valid"}, ifu_resp_valid, 1'b0);
    chk({nm, " ifu_resp_data"}, ifu_resp_data, 32'h0);
    chk1({nm, " lsu_resp_valid"}, lsu_resp_valid, 1'b0);
    chk({nm, " lsu_resp_rdata"}, lsu_resp_rdata, 32'h0);
    chk1({nm, " mem_req_valid"}, mem_req_valid, 1'b0);
    chk({nm, " mem_req_addr"}, mem_req_addr, 32'h0);
    chk1({nm, " mem_req_wen"}, mem_req_wen, 1'b0);
    chk({nm, " mem_req_wdata"}, mem_req_wdata, 32'h0);
    chk({nm, " mem_req_wmask"}, 32'(mem_req_wmask), 32'h0);
  endtask

  // One complete transaction against a memory that accepts at once and
  // answers in the following cycle.
  task automatic zero_wait(input vec_t v, input string nm);
    ifu_req_valid  = v.ifu_v;
    lsu_req_valid  = v.lsu_v;
    ifu_req_addr   = v.iaddr;
    lsu_req_addr   = v.laddr;
    lsu_req_wen    = v.wen;
    lsu_req_wdata  = v.wdata;
    lsu_req_wmask  = v.wmask;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    #1;
    chk1({nm, " ifu_req_ready"}, ifu_req_ready, !v.exp_lsu);
    chk1({nm, " lsu_req_ready"}, lsu_req_ready, v.exp_lsu);
    tick();  // accept edge
    #1;
    chk1({nm, " mem_req_valid"}, mem_req_valid, 1'b1);
    chk({nm, " mem_req_addr"}, mem_req_addr, v.exp_lsu ? v.laddr : v.iaddr);
    chk1({nm, " mem_req_wen"}, mem_req_wen, v.exp_lsu & v.wen);
    chk({nm, " mem_req_wmask"}, 32'(mem_req_wmask), v.exp_lsu ? 32'(v.wmask) : 32'h0);
    if (v.exp_lsu && v.wen) chk({nm, " mem_req_wdata"}, mem_req_wdata, v.wdata);
    chk1({nm, " busy ifu_ready"}, ifu_req_ready, 1'b0);
    chk1({nm, " busy lsu_ready"}, lsu_req_ready, 1'b0);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    tick();  // memory accepts
    chk1({nm, " mem_req_valid wait"}, mem_req_valid, 1'b0);
    chk1({nm, " early ifu_resp"}, ifu_resp_valid, 1'b0);
    chk1({nm, " early lsu_resp"}, lsu_resp_valid, 1'b0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = v.mdata;
    tick();  // response registered
    mem_resp_valid = 1'b0;
    chk1({nm, " ifu_resp_valid"}, ifu_resp_valid, !v.exp_lsu);
    chk1({nm, " lsu_resp_valid"}, lsu_resp_valid, v.exp_lsu);
    if (v.exp_lsu) chk({nm, " lsu_resp_rdata"}, lsu_resp_rdata, v.exp_data);
    else           chk({nm, " ifu_resp_data"}, ifu_resp_data, v.exp_data);
    tick();
    chk1({nm, " pulse end ifu"}, ifu_resp_valid, 1'b0);
    chk1({nm, " pulse end lsu"}, lsu_resp_valid, 1'b0);
    if (v.exp_lsu) chk({nm, " lsu_rdata hold"}, lsu_resp_rdata, v.exp_data);
    else           chk({nm, " ifu_data hold"}, ifu_resp_data, v.exp_data);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0,         32'h0,         4'h0, 32'h0000_0413, 1'b0, 32'h0000_0413};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h8000_0004, 32'h8000_0100, 32'h0,         4'h0, 32'h1111_2222, 1'b1, 32'h1111_2222};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h8000_0004, 32'h8000_0100, 32'h0,         4'h0, 32'h0010_0093, 1'b0, 32'h0010_0093};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h8000_0008, 32'h8000_0200, 32'hA5A5_A5A5, 4'h3, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0,         32'h8000_0204, 32'h0102_0304, 4'hC, 32'h0BAD_F00D, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h8000_0008, 32'h8000_0300, 32'h0,         4'h0, 32'h0000_0013, 1'b0, 32'h0000_0013};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h8000_000C, 32'h0,         32'h0,         4'h0, 32'h0000_006F, 1'b0, 32'h0000_006F};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h8000_0010, 32'h8000_0400, 32'h0,         4'h0, 32'h8765_4321, 1'b1, 32'h8765_4321};

    // Reset state
    do_reset();
    check_all_zero("reset");

    // Table of zero-wait transactions (includes the IFU-only read)
    for (int i = 0; i < 8; i++) zero_wait(vecs[i], $sformatf("vec%0d", i));

    // Tie held continuously after reset: IFU, LSU, IFU, LSU
    begin
      logic [3:0] gseq;
      int         ng;
      logic       pend;
      do_reset();
      gseq = '0;
      ng   = 0;
      pend = 1'b0;
      ifu_req_valid = 1'b1;
      lsu_req_valid = 1'b1;
      ifu_req_addr  = 32'h8000_1000;
      lsu_req_addr  = 32'h8000_2000;
      mem_req_ready = 1'b1;
      for (int c = 0; c < 60 && ng < 4; c++) begin
        mem_resp_valid = pend;
        mem_resp_data  = 32'h0000_00AA;
        #1;
        if (ifu_req_ready && lsu_req_ready) chk1("tie both ready", 1'b1, 1'b0);
        if (ifu_req_ready)      begin gseq[ng] = 1'b0; ng++; end
        else if (lsu_req_ready) begin gseq[ng] = 1'b1; ng++; end
        pend = mem_req_valid;
        tick();
      end
      chk("tie grant count", 32'(ng), 32'd4);
      chk("tie grant order", 32'(gseq), 32'h0000_000A);
    end

    // LSU store with memory backpressure for 4 cycles
    begin
      int   cnt;
      logic done;
      do_reset();
      lsu_req_valid = 1'b1;
      lsu_req_wen   = 1'b1;
      lsu_req_addr  = 32'h8000_1000;
      lsu_req_wdata = 32'hDEAD_BEEF;
      lsu_req_wmask = 4'hF;
      #1;
      chk1("bp lsu_ready", lsu_req_ready, 1'b1);
      tick();
      lsu_req_valid = 1'b0;
      lsu_req_wdata = 32'h0;
      lsu_req_addr  = 32'h0;
      cnt  = 0;
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
        if (mem_req_valid) begin
          cnt++;
          chk("bp addr", mem_req_addr, 32'h8000_1000);
          chk("bp wdata", mem_req_wdata, 32'hDEAD_BEEF);
          chk("bp wmask", 32'(mem_req_wmask), 32'hF);
          chk1("bp wen", mem_req_wen, 1'b1);
          mem_req_ready = (cnt >= 5);
          tick();
        end else begin
          done = 1'b1;
        end
      end
      chk("bp valid cycles", 32'(cnt), 32'd5);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'hCAFE_F00D;
      tick();
      mem_resp_valid = 1'b0;
      chk1("bp lsu_resp_valid", lsu_resp_valid, 1'b1);
      chk("bp lsu_resp_rdata", lsu_resp_rdata, 32'h0);
      chk1("bp ifu_resp_valid", ifu_resp_valid, 1'b0);
    end

    // Spurious memory response while idle; request dropped before acceptance
    do_reset();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h1234_5678;
    tick();
    mem_resp_valid = 1'b0;
    chk1("spur ifu_resp_valid", ifu_resp_valid, 1'b0);
    chk1("spur lsu_resp_valid", lsu_resp_valid, 1'b0);
    chk("spur ifu_resp_data", ifu_resp_data, 32'h0);
    chk("spur lsu_resp_rdata", lsu_resp_rdata, 32'h0);
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0040;
    #1;
    chk1("spur still idle", ifu_req_ready, 1'b1);
    ifu_req_valid = 1'b0;
    tick();
    chk1("drop no request", mem_req_valid, 1'b0);
    chk("drop no latch", mem_req_addr, 32'h0);

    // Reset in WAIT aborts the transaction; late response is dropped
    zero_wait(vecs[0], "pre-abort");
    lsu_req_valid = 1'b1;
    lsu_req_wen   = 1'b1;
    lsu_req_addr  = 32'h8000_3000;
    lsu_req_wdata = 32'h5555_AAAA;
    lsu_req_wmask = 4'h6;
    mem_req_ready = 1'b1;
    tick();  // accept
    lsu_req_valid = 1'b0;
    tick();  // memory accepts, now waiting
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("abort");
    mem_req_ready = 1'b0;
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h7777_7777;
    tick();
    mem_resp_valid = 1'b0;
    chk1("abort late ifu_resp", ifu_resp_valid, 1'b0);
    chk1("abort late lsu_resp", lsu_resp_valid, 1'b0);
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    #1;
    chk1("abort tie ifu", ifu_req_ready, 1'b1);
    chk1("abort tie lsu", lsu_req_ready, 1'b0);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;

    // Randomized traffic against a transaction-level model
    begin
      logic        m_busy, m_sent, m_last, m_owner, m_wen;
      logic [31:0] m_addr, m_wdata;
      logic [3:0]  m_wmask;
      int unsigned m_delay;
      logic        p_ifu, p_lsu;
      logic [31:0] p_data;
      logic        e_i, e_l;
      do_reset();
      m_busy = 1'b0; m_sent = 1'b0; m_last = 1'b1; m_owner = 1'b0; m_wen = 1'b0;
      m_addr = '0; m_wdata = '0; m_wmask = '0; m_delay = 0;
      p_ifu = 1'b0; p_lsu = 1'b0; p_data = '0;
      for (int c = 0; c < 3000; c++) begin
        if (p_ifu) hold_ifu = p_data;
        if (p_lsu) hold_lsu = p_data;
        chk1("rnd ifu_resp_valid", ifu_resp_valid, p_ifu);
        chk1("rnd lsu_resp_valid", lsu_resp_valid, p_lsu);
        chk("rnd ifu_resp_data", ifu_resp_data, hold_ifu);
        chk("rnd lsu_resp_rdata", lsu_resp_rdata, hold_lsu);
        p_ifu = 1'b0;
        p_lsu = 1'b0;

        ifu_req_valid = ($urandom_range(0, 2) != 0);
        lsu_req_valid = ($urandom_range(0, 2) != 0);
        ifu_req_addr  = $urandom;
        lsu_req_addr  = $urandom;
        lsu_req_wen   = 1'($urandom_range(0, 1));
        lsu_req_wdata = $urandom;
        lsu_req_wmask = 4'($urandom_range(0, 15));
        mem_req_ready = 1'($urandom_range(0, 1));
        mem_resp_data = $urandom;
        if (m_busy && m_sent) begin
          if (m_delay == 0) mem_resp_valid = 1'b1;
          else begin
            mem_resp_valid = 1'b0;
            m_delay--;
          end
        end else begin
          mem_resp_valid = ($urandom_range(0, 7) == 0);
        end
        #1;

        e_i = !m_busy && ifu_req_valid && (!lsu_req_valid || m_last);
        e_l = !m_busy && lsu_req_valid && (!ifu_req_valid || !m_last);
        chk1("rnd ifu_req_ready", ifu_req_ready, e_i);
        chk1("rnd lsu_req_ready", lsu_req_ready, e_l);
        chk1("rnd mem_req_valid", mem_req_valid, m_busy && !m_sent);
        if (m_busy && !m_sent) begin
          chk("rnd mem_req_addr", mem_req_addr, m_addr);
          chk1("rnd mem_req_wen", mem_req_wen, m_wen);
          chk("rnd mem_req_wmask", 32'(mem_req_wmask), 32'(m_wmask));
          if (m_owner) chk("rnd mem_req_wdata", mem_req_wdata, m_wdata);
        end else begin
          chk1("rnd idle wen", mem_req_wen, 1'b0);
          chk("rnd idle wmask", 32'(mem_req_wmask), 32'h0);
        end

        if (!m_busy) begin
          if (e_i) begin
            m_busy = 1'b1; m_sent = 1'b0; m_owner = 1'b0; m_last = 1'b0;
            m_addr = ifu_req_addr; m_wen = 1'b0; m_wmask = '0; m_wdata = '0;
          end else if (e_l) begin
            m_busy = 1'b1; m_sent = 1'b0; m_owner = 1'b1; m_last = 1'b1;
            m_addr = lsu_req_addr; m_wen = lsu_req_wen;
            m_wmask = lsu_req_wmask; m_wdata = lsu_req_wdata;
          end
        end else if (!m_sent) begin
          if (mem_req_ready) begin
            m_sent  = 1'b1;
            m_delay = $urandom_range(0, 3);
          end
        end else if (mem_resp_valid) begin
          m_busy = 1'b0;
          m_sent = 1'b0;
          p_ifu  = !m_owner;
          p_lsu  = m_owner;
          p_data = (m_owner && m_wen) ? 32'h0 : mem_resp_data;
        end
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
